// File: rtl/cascade_idelay_train.sv
// -----------------------------------------------------------------------------
// cascade_idelay_train
//
// Per-lane IDELAY tap calibration controller for the cascade PHY input lanes.
// A sweep loads every tap value (0 .. 2^TAP_W-1) on all lanes at once. After
// each load it waits SETTLE_CYC cycles, then ANDs the per-lane checker pass
// flag over SAMPLE_CYC cycles. The widest passing window on each lane is
// tracked, and each lane is finally loaded with the centre of that window.
// A lane whose best window is shorter than MIN_EYE gets DEFAULT_TAP and is
// flagged as failed. In IDLE/DONE a manual mode passes the software-supplied
// ce/inc/ld/value straight through, delayed by one register stage.
//
// Ports:
//   i_clk        control clock
//   i_rst_n      asynchronous active-low reset
//   i_start      pulse, starts a sweep (IDLE/DONE only, ignored if i_man_en)
//   i_lane_ok    per-lane training checker pass flag
//   i_man_en     manual override select (honoured in IDLE/DONE only)
//   i_man_ce     manual CE per lane
//   i_man_inc    manual INC per lane
//   i_man_ld     manual LD per lane
//   i_man_val    manual CNTVALUEIN, lane i at [i*TAP_W +: TAP_W]
//   o_delay_ce   IDELAY CE
//   o_delay_inc  IDELAY INC
//   o_delay_ld   IDELAY LD
//   o_delay_val  IDELAY CNTVALUEIN, lane i at [i*TAP_W +: TAP_W]
//   o_busy       high from LOAD through FINAL
//   o_done       high while in DONE
//   o_lane_fail  lane best window < MIN_EYE (valid with o_done)
//   o_eye_len    best window length per lane, lane i at [i*(TAP_W+1) +: TAP_W+1]
//   o_dbg_state  current FSM state encoding (debug observation only)
//
// Every output is a register: each cycle the next-state logic computes the
// value an output must carry in the coming state, and the edge that enters
// that state loads it.
// -----------------------------------------------------------------------------
module cascade_idelay_train #(
    parameter int LANE_NUM    = 3,
    parameter int TAP_W       = 5,
    parameter int SETTLE_CYC  = 8,
    parameter int SAMPLE_CYC  = 16,
    parameter int MIN_EYE     = 4,
    parameter int DEFAULT_TAP = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [LANE_NUM-1:0]           i_lane_ok,
    input  logic                          i_man_en,
    input  logic [LANE_NUM-1:0]           i_man_ce,
    input  logic [LANE_NUM-1:0]           i_man_inc,
    input  logic [LANE_NUM-1:0]           i_man_ld,
    input  logic [LANE_NUM*TAP_W-1:0]     i_man_val,
    output logic [LANE_NUM-1:0]           o_delay_ce,
    output logic [LANE_NUM-1:0]           o_delay_inc,
    output logic [LANE_NUM-1:0]           o_delay_ld,
    output logic [LANE_NUM*TAP_W-1:0]     o_delay_val,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [LANE_NUM-1:0]           o_lane_fail,
    output logic [LANE_NUM*(TAP_W+1)-1:0] o_eye_len,
    output logic [2:0]                    o_dbg_state
);

    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_UPDATE = 3'd4,
        S_FINAL  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                           state_q, state_d;
    logic [TAP_W-1:0]                 tap_q, tap_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [LANE_NUM-1:0]              pass_q, pass_d;
    logic [LANE_NUM-1:0][TAP_W:0]     cur_len_q, cur_len_d;
    logic [LANE_NUM-1:0][TAP_W:0]     best_len_q, best_len_d;
    logic [LANE_NUM-1:0][TAP_W-1:0]   cur_start_q, cur_start_d;
    logic [LANE_NUM-1:0][TAP_W-1:0]   best_start_q, best_start_d;

    logic [LANE_NUM-1:0]              ce_q, ce_d;
    logic [LANE_NUM-1:0]              inc_q, inc_d;
    logic [LANE_NUM-1:0]              ld_q, ld_d;
    logic [LANE_NUM*TAP_W-1:0]        val_q, val_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [LANE_NUM-1:0]              fail_q, fail_d;
    logic [LANE_NUM*(TAP_W+1)-1:0]    eye_q, eye_d;

    // Per-lane working values for the UPDATE step
    logic [LANE_NUM-1:0][TAP_W:0]     eff_len;
    logic [LANE_NUM-1:0][TAP_W-1:0]   eff_start;
    logic [LANE_NUM-1:0][TAP_W:0]     half_len;

    logic                             tap_last;
    logic [TAP_W-1:0]                 tap_nxt;

    assign tap_last = (tap_q == {TAP_W{1'b1}});
    assign tap_nxt  = tap_q + TAP_W'(1);

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        cur_len_d    = cur_len_q;
        best_len_d   = best_len_q;
        cur_start_d  = cur_start_q;
        best_start_d = best_start_q;
        ce_d         = '0;
        inc_d        = '0;
        ld_d         = '0;
        val_d        = val_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        eye_d        = eye_q;
        eff_len      = '0;
        eff_start    = '0;
        half_len     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start && !i_man_en) begin
                    state_d      = S_LOAD;
                    tap_d        = '0;
                    cur_len_d    = '0;
                    best_len_d   = '0;
                    cur_start_d  = '0;
                    best_start_d = '0;
                    pass_d       = '1;
                    ld_d         = '1;
                    val_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                end else if (i_man_en) begin
                    ce_d  = i_man_ce;
                    inc_d = i_man_inc;
                    ld_d  = i_man_ld;
                    val_d = i_man_val;
                end
            end

            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = '0;
            end

            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SAMPLE: begin
                // A single low cycle anywhere in the window fails the tap
                pass_d = pass_q & i_lane_ok;
                if (cnt_q == CNT_W'(SAMPLE_CYC - 1)) begin
                    state_d = S_UPDATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_UPDATE: begin
                for (int l = 0; l < LANE_NUM; l++) begin
                    // Window as it stands including this tap's result
                    if (pass_q[l]) begin
                        eff_len[l]   = cur_len_q[l] + 1'b1;
                        eff_start[l] = (cur_len_q[l] == '0) ? tap_q : cur_start_q[l];
                    end else begin
                        eff_len[l]   = cur_len_q[l];
                        eff_start[l] = cur_start_q[l];
                    end
                    // Close out on a failing tap, or at the last tap for a
                    // window still open. Strict '>' keeps the earliest window.
                    if ((!pass_q[l] || tap_last) && (eff_len[l] > best_len_q[l])) begin
                        best_len_d[l]   = eff_len[l];
                        best_start_d[l] = eff_start[l];
                    end
                    cur_len_d[l]   = pass_q[l] ? eff_len[l] : '0;
                    cur_start_d[l] = eff_start[l];
                end

                ld_d = '1;
                if (tap_last) begin
                    // The final load is computed from the just-closed best
                    // windows so it can be presented in FINAL.
                    state_d = S_FINAL;
                    for (int l = 0; l < LANE_NUM; l++) begin
                        half_len[l] = (best_len_d[l] - 1'b1) >> 1;
                        if (best_len_d[l] >= (TAP_W+1)'(MIN_EYE)) begin
                            val_d[l*TAP_W +: TAP_W] = best_start_d[l] + half_len[l][TAP_W-1:0];
                            fail_d[l]               = 1'b0;
                        end else begin
                            val_d[l*TAP_W +: TAP_W] = TAP_W'(DEFAULT_TAP);
                            fail_d[l]               = 1'b1;
                        end
                        eye_d[l*(TAP_W+1) +: (TAP_W+1)] = best_len_d[l];
                    end
                end else begin
                    state_d = S_LOAD;
                    tap_d   = tap_nxt;
                    pass_d  = '1;
                    val_d   = {LANE_NUM{tap_nxt}};
                end
            end

            S_FINAL: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            cnt_q        <= '0;
            pass_q       <= '0;
            cur_len_q    <= '0;
            best_len_q   <= '0;
            cur_start_q  <= '0;
            best_start_q <= '0;
            ce_q         <= '0;
            inc_q        <= '0;
            ld_q         <= '0;
            val_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= '0;
            eye_q        <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            cur_len_q    <= cur_len_d;
            best_len_q   <= best_len_d;
            cur_start_q  <= cur_start_d;
            best_start_q <= best_start_d;
            ce_q         <= ce_d;
            inc_q        <= inc_d;
            ld_q         <= ld_d;
            val_q        <= val_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            eye_q        <= eye_d;
        end
    end

    assign o_delay_ce  = ce_q;
    assign o_delay_inc = inc_q;
    assign o_delay_ld  = ld_q;
    assign o_delay_val = val_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_lane_fail = fail_q;
    assign o_eye_len   = eye_q;
    assign o_dbg_state = state_q;

endmodule
